dt_param: RTL

- Parametrised two-pass distance transform engine, successor to the fixed 128x128 chessboard DT block.
- Reads a binary image, packed STI_W pixels per word, from a read-only source memory (sti). Writes a DIST_W-bit distance map into a read/write result memory (res).
- Adds run-time metric selection (city-block or chessboard), a start/busy/done handshake and saturating distances. Sits between the image ROM and result RAM in the DT subsystem.

---
 rtl/dt_param_if.sv | 33 +++
 rtl/dt_param.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dt_param_if.sv
// Bundle between the distance-transform engine and its controller / image ROM / result RAM.
// master = engine side, slave = controller plus memories.
interface dt_param_if #(
    parameter int unsigned IMG_W  = 128,
    parameter int unsigned IMG_H  = 128,
    parameter int unsigned STI_W  = 16,
    parameter int unsigned DIST_W = 8,
    parameter int unsigned STI_AW = $clog2(IMG_W*IMG_H/STI_W),
    parameter int unsigned RES_AW = $clog2(IMG_W*IMG_H)
);
    logic              start;
    logic              mode;
    logic              busy;
    logic              done;
    logic              sti_rd;
    logic [STI_AW-1:0] sti_addr;
    logic [STI_W-1:0]  sti_di;
    logic              res_rd;
    logic              res_wr;
    logic [RES_AW-1:0] res_addr;
    logic [DIST_W-1:0] res_do;
    logic [DIST_W-1:0] res_di;

    modport master (
        input  start, mode, sti_di, res_di,
        output busy, done, sti_rd, sti_addr, res_rd, res_wr, res_addr, res_do
    );

    modport slave (
        output start, mode, sti_di, res_di,
        input  busy, done, sti_rd, sti_addr, res_rd, res_wr, res_addr, res_do
    );
endinterface

// File: rtl/dt_param.sv
// Two-pass distance transform (city-block or chessboard) over a packed binary image,
// with saturating distances and a start/busy/done handshake.
module dt_param #(
    parameter int unsigned IMG_W  = 128,
    parameter int unsigned IMG_H  = 128,
    parameter int unsigned STI_W  = 16,
    parameter int unsigned DIST_W = 8,
    parameter int unsigned STI_AW = $clog2(IMG_W*IMG_H/STI_W),
    parameter int unsigned RES_AW = $clog2(IMG_W*IMG_H)
) (
    input  logic       clk,
    input  logic       reset,
    dt_param_if.master bus
);
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned BW = (STI_W > 1) ? $clog2(STI_W) : 1;

    localparam logic [DIST_W-1:0] DMAX   = '1;
    localparam logic [RW-1:0]     R_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0]     C_LAST = CW'(IMG_W - 1);
    localparam logic [BW-1:0]     B_TOP  = BW'(STI_W - 1);

    // Each state names the memory operation presented on the bus during that cycle.
    typedef enum logic [2:0] {
        S_IDLE,
        S_F_STI,
        S_F_RD,
        S_F_WR,
        S_B_CUR,
        S_B_RD,
        S_B_WR,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     r_q, r_d;
    logic [CW-1:0]     c_q, c_d;
    logic [1:0]        k_q, k_d;
    logic [BW-1:0]     bi_q, bi_d;
    logic [STI_AW-1:0] wa_q, wa_d;
    logic              mode_q, mode_d;
    logic [DIST_W-1:0] min_q, min_d;
    logic [DIST_W-1:0] nb_q, nb_d;
    logic [DIST_W-1:0] cur_q, cur_d;
    logic [STI_W-1:0]  word_q, word_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sti_rd_q, sti_rd_d;
    logic [STI_AW-1:0] sti_addr_q, sti_addr_d;
    logic              res_rd_q, res_rd_d;
    logic              res_wr_q, res_wr_d;
    logic [RES_AW-1:0] res_addr_q, res_addr_d;
    logic [DIST_W-1:0] res_do_q, res_do_d;

    logic [DIST_W-1:0] wdata;
    logic [DIST_W-1:0] rd_min;
    logic [DIST_W-1:0] eval_w;
    logic              eval;
    logic              eval_bit;
    logic              bwd_adv;
    logic [1:0]        k_first;
    logic [1:0]        k_last;
    logic [RES_AW-1:0] pix_addr;
    logic [RES_AW-1:0] row_addr;

    function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] v);
        logic [DIST_W:0] s;
        s = {1'b0, v} + (DIST_W+1)'(1);
        return s[DIST_W] ? DMAX : s[DIST_W-1:0];
    endfunction

    function automatic logic [DIST_W-1:0] dmin(input logic [DIST_W-1:0] a,
                                               input logic [DIST_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // City-block only needs the column-aligned neighbour; chessboard needs the three-wide row.
    assign k_first = mode_q ? 2'd0 : 2'd1;
    assign k_last  = mode_q ? 2'd2 : 2'd1;
    assign rd_min  = dmin(min_q, bus.res_di);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        c_d        = c_q;
        k_d        = k_q;
        bi_d       = bi_q;
        wa_d       = wa_q;
        mode_d     = mode_q;
        min_d      = min_q;
        nb_d       = nb_q;
        cur_d      = cur_q;
        word_d     = word_q;
        wdata      = '0;
        eval       = 1'b0;
        eval_bit   = 1'b0;
        eval_w     = '0;
        bwd_adv    = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        sti_rd_d   = 1'b0;
        sti_addr_d = sti_addr_q;
        res_rd_d   = 1'b0;
        res_wr_d   = 1'b0;
        res_addr_d = res_addr_q;
        res_do_d   = res_do_q;
        pix_addr   = '0;
        row_addr   = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d  = bus.mode;
                    r_d     = '0;
                    c_d     = '0;
                    bi_d    = B_TOP;
                    wa_d    = '0;
                    nb_d    = '0;
                    state_d = S_F_STI;
                end
            end
            S_F_STI: begin
                word_d   = bus.sti_di;
                eval     = 1'b1;
                eval_bit = bus.sti_di[bi_q];
                eval_w   = nb_q;
            end
            S_F_RD: begin
                min_d = rd_min;
                if (k_q == k_last) begin
                    wdata   = sat_inc(rd_min);
                    state_d = S_F_WR;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            S_F_WR: begin
                nb_d = res_do_q;
                if (r_q == R_LAST && c_q == C_LAST) begin
                    state_d = S_B_CUR;
                end else begin
                    if (c_q == C_LAST) begin
                        c_d = '0;
                        r_d = r_q + RW'(1);
                    end else begin
                        c_d = c_q + CW'(1);
                    end
                    if (bi_q == '0) begin
                        bi_d    = B_TOP;
                        wa_d    = wa_q + STI_AW'(1);
                        state_d = S_F_STI;
                    end else begin
                        bi_d     = bi_q - BW'(1);
                        eval     = 1'b1;
                        eval_bit = word_q[bi_d];
                        eval_w   = res_do_q;
                    end
                end
            end
            S_B_CUR: begin
                // A forward value of zero can only be background: nothing to refine.
                cur_d = bus.res_di;
                if (bus.res_di == '0) begin
                    nb_d    = '0;
                    bwd_adv = 1'b1;
                end else if (r_q == R_LAST || c_q == C_LAST || (mode_q && c_q == '0)) begin
                    wdata   = DIST_W'(1);
                    state_d = S_B_WR;
                end else begin
                    min_d   = nb_q;
                    k_d     = k_first;
                    state_d = S_B_RD;
                end
            end
            S_B_RD: begin
                min_d = rd_min;
                if (k_q == k_last) begin
                    wdata   = dmin(cur_q, sat_inc(rd_min));
                    state_d = S_B_WR;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            S_B_WR: begin
                nb_d    = res_do_q;
                bwd_adv = 1'b1;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bwd_adv) begin
            if (r_q == '0 && c_q == '0) begin
                state_d = S_FIN;
            end else begin
                if (c_q == '0) begin
                    c_d = C_LAST;
                    r_d = r_q - RW'(1);
                end else begin
                    c_d = c_q - CW'(1);
                end
                state_d = S_B_CUR;
            end
        end

        // Any out-of-image neighbour reads as 0, so an edge object pixel is simply 1.
        if (eval) begin
            if (!eval_bit) begin
                wdata   = '0;
                state_d = S_F_WR;
            end else if (r_d == '0 || c_d == '0 || (mode_q && c_d == C_LAST)) begin
                wdata   = DIST_W'(1);
                state_d = S_F_WR;
            end else begin
                min_d   = eval_w;
                k_d     = k_first;
                state_d = S_F_RD;
            end
        end

        pix_addr = RES_AW'(r_d) * RES_AW'(IMG_W) + RES_AW'(c_d);
        row_addr = (state_d == S_F_RD) ? (pix_addr - RES_AW'(IMG_W))
                                       : (pix_addr + RES_AW'(IMG_W));

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
        case (state_d)
            S_F_STI: begin
                sti_rd_d   = 1'b1;
                sti_addr_d = wa_d;
            end
            S_F_RD, S_B_RD: begin
                res_rd_d   = 1'b1;
                res_addr_d = row_addr + RES_AW'(k_d) - RES_AW'(1);
            end
            S_B_CUR: begin
                res_rd_d   = 1'b1;
                res_addr_d = pix_addr;
            end
            S_F_WR, S_B_WR: begin
                res_wr_d   = 1'b1;
                res_addr_d = pix_addr;
                res_do_d   = wdata;
            end
            default: ;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            r_q        <= '0;
            c_q        <= '0;
            k_q        <= '0;
            bi_q       <= '0;
            wa_q       <= '0;
            mode_q     <= 1'b0;
            min_q      <= '0;
            nb_q       <= '0;
            cur_q      <= '0;
            word_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sti_rd_q   <= 1'b0;
            sti_addr_q <= '0;
            res_rd_q   <= 1'b0;
            res_wr_q   <= 1'b0;
            res_addr_q <= '0;
            res_do_q   <= '0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            c_q        <= c_d;
            k_q        <= k_d;
            bi_q       <= bi_d;
            wa_q       <= wa_d;
            mode_q     <= mode_d;
            min_q      <= min_d;
            nb_q       <= nb_d;
            cur_q      <= cur_d;
            word_q     <= word_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sti_rd_q   <= sti_rd_d;
            sti_addr_q <= sti_addr_d;
            res_rd_q   <= res_rd_d;
            res_wr_q   <= res_wr_d;
            res_addr_q <= res_addr_d;
            res_do_q   <= res_do_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sti_rd   = sti_rd_q;
    assign bus.sti_addr = sti_addr_q;
    assign bus.res_rd   = res_rd_q;
    assign bus.res_wr   = res_wr_q;
    assign bus.res_addr = res_addr_q;
    assign bus.res_do   = res_do_q;
endmodule
